// File: rtl/mux_n_to_1_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared types and helpers for the arbitrated N-to-1 multiplexer.
//   arb_mode_e    : arbitration mode selector (fixed priority / round-robin)
//   onehot_to_idx : converts a one-hot grant into a binary channel index
//   rr_pick       : one-hot grant of the first requester at or after ptr,
//                   wrapping modulo n (n need not be a power of two)
// Helpers work on MAX_CHAN-wide vectors; callers zero-extend and slice.
// ---------------------------------------------------------------------------
package mux_pkg;

    localparam int MAX_CHAN = 16;
    localparam int MAX_IDX  = 4;
    localparam int CNT_W    = MAX_IDX + 1;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    function automatic logic [MAX_IDX-1:0] onehot_to_idx(input logic [MAX_CHAN-1:0] oh);
        logic [MAX_IDX-1:0] idx;
        idx = '0;
        for (int k = 0; k < MAX_CHAN; k++) begin
            if (oh[k]) begin
                idx = idx | MAX_IDX'(k);
            end
        end
        return idx;
    endfunction

    // ptr < n, so ptr + s stays below 2n and a single subtraction wraps it.
    function automatic logic [MAX_CHAN-1:0] rr_pick(input logic [MAX_CHAN-1:0] valid,
                                                     input logic [MAX_IDX-1:0]  ptr,
                                                     input logic [CNT_W-1:0]    n);
        logic [MAX_CHAN-1:0] gnt;
        logic [CNT_W-1:0]    pos;
        logic                found;
        gnt   = '0;
        found = 1'b0;
        for (int s = 0; s < MAX_CHAN; s++) begin
            pos = {1'b0, ptr} + CNT_W'(s);
            if (pos >= n) begin
                pos = pos - n;
            end
            if ((CNT_W'(s) < n) && !found && valid[pos[MAX_IDX-1:0]]) begin
                gnt[pos[MAX_IDX-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/mux_n_to_1_arb_arb_rr.sv
// ---------------------------------------------------------------------------
// arb_rr
// Combinational round-robin arbiter. Grants the first requester found when
// searching from i_ptr upward with wrap-around. Tying i_ptr to 0 turns it
// into a fixed-priority (lowest index wins) arbiter.
// Ports:
//   i_req [CHAN_NUM]  : request vector
//   i_ptr [IDX_WIDTH] : search start position (must be < CHAN_NUM)
//   i_en              : grant enable; o_gnt is all-zero when low
//   o_gnt [CHAN_NUM]  : one-hot grant, all-zero when no request
// ---------------------------------------------------------------------------
module arb_rr
    import mux_pkg::*;
#(
    parameter  int CHAN_NUM  = 4,
    localparam int IDX_WIDTH = $clog2(CHAN_NUM)
) (
    input  logic [CHAN_NUM-1:0]  i_req,
    input  logic [IDX_WIDTH-1:0] i_ptr,
    input  logic                 i_en,
    output logic [CHAN_NUM-1:0]  o_gnt
);

    logic [MAX_CHAN-1:0] w_pick;
    logic                w_unusedPick;

    assign w_pick       = rr_pick(MAX_CHAN'(i_req), MAX_IDX'(i_ptr), CNT_W'(CHAN_NUM));
    assign o_gnt        = i_en ? w_pick[CHAN_NUM-1:0] : '0;
    // Bits above CHAN_NUM are always zero and intentionally dropped.
    assign w_unusedPick = ^w_pick;

endmodule

// File: rtl/mux_n_to_1_arb.sv
// ---------------------------------------------------------------------------
// mux_n_to_1_arb
// N-to-1 data multiplexer with per-channel valid/ready, internal arbitration
// (fixed priority or round-robin) and one registered output stage.
// Ports:
//   i_clk, i_rst                  : clock, async active-high reset
//   i_valid [CHAN_NUM]            : per-channel request valid
//   o_ready [CHAN_NUM]            : per-channel accept (at most one set)
//   i_data  [CHAN_NUM*DATA_WIDTH] : flattened payloads, channel k at k*DW
//   o_valid                       : registered output beat valid
//   i_ready                       : downstream accept
//   o_data  [DATA_WIDTH]          : registered output payload
//   o_idx   [IDX_WIDTH]           : source channel of o_data
// ---------------------------------------------------------------------------
module mux_n_to_1_arb
    import mux_pkg::*;
#(
    parameter  int CHAN_NUM   = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int ARB_MODE   = 0,
    localparam int IDX_WIDTH  = $clog2(CHAN_NUM)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [CHAN_NUM-1:0]            i_valid,
    output logic [CHAN_NUM-1:0]            o_ready,
    input  logic [CHAN_NUM*DATA_WIDTH-1:0] i_data,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic [IDX_WIDTH-1:0]           o_idx
);

    localparam logic                 IS_RR    = (ARB_MODE == int'(ARB_RR));
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(CHAN_NUM - 1);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic [IDX_WIDTH-1:0]  r_ptr;

    logic                  w_ld;
    logic                  w_en;
    logic [IDX_WIDTH-1:0]  w_arbPtr;
    logic [CHAN_NUM-1:0]   w_gnt;
    logic                  w_xfer;
    logic [MAX_IDX-1:0]    w_gntIdxFull;
    logic [IDX_WIDTH-1:0]  w_gntIdx;
    logic [DATA_WIDTH-1:0] w_selData;
    logic                  w_unusedIdx;

    // Output register can take a new beat when empty or being drained.
    assign w_ld     = !r_valid || i_ready;
    // Reset must hide o_ready even though the grant logic is combinational.
    assign w_en     = w_ld && !i_rst;
    assign w_arbPtr = IS_RR ? r_ptr : '0;

    arb_rr #(
        .CHAN_NUM (CHAN_NUM)
    ) u_arb (
        .i_req (i_valid),
        .i_ptr (w_arbPtr),
        .i_en  (w_en),
        .o_gnt (w_gnt)
    );

    assign o_ready      = w_gnt;
    assign w_xfer       = |(i_valid & w_gnt);
    assign w_gntIdxFull = onehot_to_idx(MAX_CHAN'(w_gnt));
    assign w_gntIdx     = w_gntIdxFull[IDX_WIDTH-1:0];
    assign w_unusedIdx  = ^w_gntIdxFull;

    // AND-OR select over the one-hot grant; scales with CHAN_NUM without a LUT.
    always_comb begin
        w_selData = '0;
        for (int k = 0; k < CHAN_NUM; k++) begin
            w_selData = w_selData | (i_data[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_gnt[k]}});
        end
    end

    // Output stage: load on transfer, drop valid when loading with nothing granted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
        end else if (w_ld) begin
            r_valid <= w_xfer;
            if (w_xfer) begin
                r_data <= w_selData;
                r_idx  <= w_gntIdx;
            end
        end
    end

    // Round-robin pointer moves just past the winner; stays 0 in fixed mode.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (IS_RR && w_xfer) begin
            r_ptr <= (w_gntIdx == LAST_IDX) ? '0 : w_gntIdx + IDX_WIDTH'(1);
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_idx   = r_idx;

endmodule

// File: doc/mux_n_to_1_arb.md
Name: mux_n_to_1_arb

Overview:
- Parametrised N-to-1 data multiplexer with valid/ready handshakes per channel, built-in arbitration and one registered output stage.
- Succeeds the plain combinational 2-to-1 select mux: the key is no longer an input, it is produced internally by a fixed-priority or round-robin arbiter.
- Sits between several producers (e.g. LSU/IFU request ports) and a single shared consumer (bus or memory port).

Parameters:
- CHAN_NUM, 4, number of input channels; legal range 2..16, any value in range (power of two not required).
- DATA_WIDTH, 32, payload width per channel.
- ARB_MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- IDX_WIDTH (localparam), $clog2(CHAN_NUM), width of the granted-channel index.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  CHAN_NUM  per-channel request valid.
- o_ready  output  CHAN_NUM  per-channel accept; at most one bit set per cycle.
- i_data  input  CHAN_NUM*DATA_WIDTH  flattened payloads; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_valid  output  1  output beat valid (registered).
- i_ready  input  1  downstream accept.
- o_data  output  DATA_WIDTH  output payload (registered).
- o_idx  output  IDX_WIDTH  source channel of the current o_data (registered).

Behaviour:
- Reset (async assert, sync release):
  - o_valid=0, o_data=0, o_idx=0, RR pointer=0.
  - A held beat is discarded; no channel sees o_ready while i_rst=1.
- Load enable: ld = !o_valid || i_ready. This gives full throughput of 1 beat/cycle.
- Grant, combinational:
  - Evaluated only when ld=1 and |i_valid.
  - Fixed mode: lowest set index of i_valid.
  - RR mode: first set index searching ptr, ptr+1, ..., wrapping modulo CHAN_NUM.
- o_ready[k] = ld && grant_onehot[k].
  - Combinational paths exist from i_ready and i_valid to o_ready, but o_ready[k] never depends on i_data.
  - o_ready is all-zero when no channel is valid.
- Transfer on channel k: i_valid[k] && o_ready[k]. The next edge loads o_data=i_data[k], o_idx=k, o_valid=1. Latency is 1 cycle from input transfer to o_valid.
- ld=1 with no valid input: o_valid goes to 0 at the next edge. o_data and o_idx hold their last values.
- Stall (o_valid=1, i_ready=0): o_data, o_idx and o_valid stay stable, and o_ready is all-zero.
- Simultaneous pop and push (o_valid=1, i_ready=1, input valid): the new beat replaces the old one in the same edge, with no bubble.
- RR pointer:
  - Updates only on an accepted input transfer: ptr = (k == CHAN_NUM-1) ? 0 : k+1.
  - Unchanged on stall or idle.
  - Wrap-around covers non-power-of-two CHAN_NUM; ptr never exceeds CHAN_NUM-1.
  - Unused in fixed mode; held at 0 there.
- Starvation: in RR mode any continuously valid channel is granted within CHAN_NUM accepted transfers.
- Protocol assumption on producers: once asserted, i_valid[k] and its data are held until transfer. The block does not check this.
- No state machine beyond the output-register full/empty bit (o_valid) and the pointer.

Decomposition:
- Package mux_pkg:
  - arb_mode_e enum (ARB_FIXED=0, ARB_RR=1).
  - Function onehot_to_idx.
  - Function rr_pick(valid, ptr) returning a one-hot grant.
- Sub-module arb_rr (CHAN_NUM): inputs i_req, i_ptr, i_en; output o_gnt (one-hot). Its fixed-mode path is simply ptr tied to 0.
- The top holds the output register, the pointer, and the data select.
- The data select is a generic AND-OR over the one-hot grant, not a case LUT.

Test Plan:
- Reset mid-stream: o_valid=1 holding 0xAAAA_0001, assert i_rst for 1 cycle -> o_valid=0, o_data=0, o_idx=0 immediately; ptr=0 after release.
- Fixed mode, CHAN_NUM=4, i_valid=4'b1010, i_ready=1 -> o_ready=4'b0010 every cycle, and channel 3 is starved; o_idx=1 one cycle after each accept.
- RR mode, CHAN_NUM=4, all valid, data k=0x100+k, i_ready=1 -> o_idx sequence 0,1,2,3,0 on consecutive cycles; o_data 0x100..0x103, 0x100; no bubbles.
- RR wrap, CHAN_NUM=3 (non-power-of-two), i_valid=3'b101 -> grants alternate 0,2,0,2; ptr never equals 3.
- Backpressure: o_valid=1 with o_data=0x55, i_ready=0 for 5 cycles, all inputs valid -> o_ready=0, o_data stays 0x55, ptr unchanged; i_ready=1 -> next grant follows the stored ptr.
- Idle drain: single beat on channel 2, then i_valid=0, i_ready=1 -> o_valid=1 for exactly 1 cycle with o_idx=2, then 0.
